// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state encoding and forward-select codes for the hazard sequencer
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    HALT   = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_S2  = 2'd1;
  localparam logic [1:0] FWD_S3  = 2'd2;
  localparam logic [1:0] FWD_S4  = 2'd3;

  // Youngest producer wins: S2 holds the newest value for a register.
  function automatic logic [1:0] fwd_pick(input logic m2, input logic m3, input logic m4);
    if (m2)      return FWD_S2;
    else if (m3) return FWD_S3;
    else if (m4) return FWD_S4;
    else         return FWD_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline stage status in, stall/squash/forward controls out
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       used_RmRnRd_1out;
  logic [2:0]       num_Rm_1out;
  logic [2:0]       num_Rn_1out;
  logic [2:0]       num_Rd_1out;
  logic             write_2out;
  logic [2:0]       writenum_2out;
  logic             loads_2out;
  logic             write_3out;
  logic [2:0]       writenum_3out;
  logic             write_out;
  logic [2:0]       writenum_out;
  logic             branch_taken;
  logic             halt_req;

  logic             update_1in;
  logic             fetch_next_in;
  logic [4:1]       rst_p;
  logic [1:0]       fwd_Rm;
  logic [1:0]       fwd_Rn;
  logic [1:0]       fwd_Rd;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output used_RmRnRd_1out, num_Rm_1out, num_Rn_1out, num_Rd_1out,
    output write_2out, writenum_2out, loads_2out, write_3out, writenum_3out,
    output write_out, writenum_out, branch_taken, halt_req,
    input  update_1in, fetch_next_in, rst_p, fwd_Rm, fwd_Rn, fwd_Rd,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  used_RmRnRd_1out, num_Rm_1out, num_Rn_1out, num_Rd_1out,
    input  write_2out, writenum_2out, loads_2out, write_3out, writenum_3out,
    input  write_out, writenum_out, branch_taken, halt_req,
    output update_1in, fetch_next_in, rst_p, fwd_Rm, fwd_Rn, fwd_Rd,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand producer match and forward-source priority select
module fwd_select (
  input  logic       used_i,
  input  logic [2:0] num_i,
  input  logic       wr2_i,
  input  logic [2:0] wn2_i,
  input  logic       ld2_i,
  input  logic       wr3_i,
  input  logic [2:0] wn3_i,
  input  logic       ld3_i,
  input  logic       wr4_i,
  input  logic [2:0] wn4_i,
  output logic [1:0] sel_o,
  output logic       load_use_o
);
  import pipeline_pkg::*;

  logic m2, m3, m4;

  assign m2 = used_i & wr2_i & (wn2_i == num_i);
  assign m3 = used_i & wr3_i & (wn3_i == num_i);
  assign m4 = used_i & wr4_i & (wn4_i == num_i);

  // A load's data is not on the S2/S3 result path yet, so those matches cannot forward.
  assign sel_o      = fwd_pick(m2 & ~ld2_i, m3 & ~ld3_i, m4);
  assign load_use_o = m2 & ld2_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline sequencer: load-use interlock, branch flush, halt, counters
module pipeline_hazard_ctrl #(
  parameter int         LOAD_BUBBLES = 2,
  parameter logic [3:0] FLUSH_MASK   = 4'b0111,
  parameter int         CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  import pipeline_pkg::*;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  hz_state_t        state_q, state_d;
  logic [1:0]       bub_q, bub_d;
  logic             pend_q, pend_d;
  logic             loads_3q, loads_3d;
  logic             live_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             upd, fet;
  logic [4:1]       rp;
  logic [1:0]       sel_m, sel_n, sel_d;
  logic [2:0]       lu;
  logic             load_use;

  fwd_select u_fwd_rm (
    .used_i(hz.used_RmRnRd_1out[2]), .num_i(hz.num_Rm_1out),
    .wr2_i(hz.write_2out), .wn2_i(hz.writenum_2out), .ld2_i(hz.loads_2out),
    .wr3_i(hz.write_3out), .wn3_i(hz.writenum_3out), .ld3_i(loads_3q),
    .wr4_i(hz.write_out),  .wn4_i(hz.writenum_out),
    .sel_o(sel_m), .load_use_o(lu[2])
  );

  fwd_select u_fwd_rn (
    .used_i(hz.used_RmRnRd_1out[1]), .num_i(hz.num_Rn_1out),
    .wr2_i(hz.write_2out), .wn2_i(hz.writenum_2out), .ld2_i(hz.loads_2out),
    .wr3_i(hz.write_3out), .wn3_i(hz.writenum_3out), .ld3_i(loads_3q),
    .wr4_i(hz.write_out),  .wn4_i(hz.writenum_out),
    .sel_o(sel_n), .load_use_o(lu[1])
  );

  fwd_select u_fwd_rd (
    .used_i(hz.used_RmRnRd_1out[0]), .num_i(hz.num_Rd_1out),
    .wr2_i(hz.write_2out), .wn2_i(hz.writenum_2out), .ld2_i(hz.loads_2out),
    .wr3_i(hz.write_3out), .wn3_i(hz.writenum_3out), .ld3_i(loads_3q),
    .wr4_i(hz.write_out),  .wn4_i(hz.writenum_out),
    .sel_o(sel_d), .load_use_o(lu[0])
  );

  assign load_use = |lu;

  // live_q stays low for the first cycle after reset release, keeping every stage squashed.
  always_comb begin
    upd = 1'b0;
    fet = 1'b0;
    rp  = 4'b1111;
    if (live_q) begin
      case (state_q)
        RUN: begin
          upd = 1'b1;
          fet = 1'b1;
          rp  = 4'b0000;
        end
        LSTALL: rp = 4'b0010;
        FLUSH: begin
          upd = 1'b1;
          fet = 1'b1;
          rp  = {1'b0, FLUSH_MASK[2:0]};
        end
        HALT: rp = 4'b0000;
        default: rp = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    pend_d  = pend_q;
    if (live_q) begin
      case (state_q)
        RUN: begin
          if (hz.branch_taken) begin
            state_d = FLUSH;
          end else if (hz.halt_req) begin
            state_d = HALT;
          end else if (load_use) begin
            state_d = LSTALL;
            bub_d   = BUB_INIT;
          end
        end
        LSTALL: begin
          if (hz.branch_taken) begin
            state_d = FLUSH;
            bub_d   = 2'd0;
          end else if (bub_q == 2'd0) begin
            state_d = RUN;
          end else begin
            bub_d = bub_q - 2'd1;
          end
        end
        FLUSH: state_d = RUN;
        HALT: begin
          // A branch resolved while frozen is held until the freeze lifts.
          if (!hz.halt_req) begin
            state_d = (pend_q | hz.branch_taken) ? FLUSH : RUN;
            pend_d  = 1'b0;
          end else if (hz.branch_taken) begin
            pend_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    loads_3d = rp[3] ? 1'b0 : hz.loads_2out;
    stall_d  = stall_q;
    flush_d  = flush_q;
    if (live_q && !upd && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (state_d == FLUSH && state_q != FLUSH && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      bub_q    <= 2'd0;
      pend_q   <= 1'b0;
      loads_3q <= 1'b0;
      live_q   <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      bub_q    <= bub_d;
      pend_q   <= pend_d;
      loads_3q <= loads_3d;
      live_q   <= 1'b1;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign hz.update_1in    = upd;
  assign hz.fetch_next_in = fet;
  assign hz.rst_p         = rp;
  assign hz.fwd_Rm        = live_q ? sel_m : FWD_REG;
  assign hz.fwd_Rn        = live_q ? sel_n : FWD_REG;
  assign hz.fwd_Rd        = live_q ? sel_d : FWD_REG;
  assign hz.stall_cnt     = stall_q;
  assign hz.flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vectors with a queued expected-response scoreboard
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string tag;
    int    upd;
    int    fet;
    int    rp;
    int    fm;
    int    fn;
    int    fd;
    int    sc;
    int    fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz();

  pipeline_hazard_ctrl #(
    .LOAD_BUBBLES(2),
    .FLUSH_MASK(4'b0111),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .hz(hz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic si(input logic [2:0] used, input logic [2:0] rm, input logic [2:0] rn,
                    input logic [2:0] rd, input logic w2, input logic [2:0] wn2, input logic l2,
                    input logic w3, input logic [2:0] wn3, input logic w4, input logic [2:0] wn4,
                    input logic bt, input logic hr);
    hz.used_RmRnRd_1out = used;
    hz.num_Rm_1out      = rm;
    hz.num_Rn_1out      = rn;
    hz.num_Rd_1out      = rd;
    hz.write_2out       = w2;
    hz.writenum_2out    = wn2;
    hz.loads_2out       = l2;
    hz.write_3out       = w3;
    hz.writenum_3out    = wn3;
    hz.write_out        = w4;
    hz.writenum_out     = wn4;
    hz.branch_taken     = bt;
    hz.halt_req         = hr;
  endtask

  task automatic clr();
    si(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic ex(input string tag, input int upd, input int fet, input int rp, input int fm,
                    input int fn, input int fd, input int sc, input int fc);
    exp_t e;
    e = '{tag, upd, fet, rp, fm, fn, fd, sc, fc};
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input int act, input int req);
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, req);
    end
  endtask

  // Outputs are compared on the falling edge, half a cycle after stimulus settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        cmp(e.tag, "update_1in",    int'(hz.update_1in),    e.upd);
        cmp(e.tag, "fetch_next_in", int'(hz.fetch_next_in), e.fet);
        cmp(e.tag, "rst_p",         int'(hz.rst_p),         e.rp);
        cmp(e.tag, "fwd_Rm",        int'(hz.fwd_Rm),        e.fm);
        cmp(e.tag, "fwd_Rn",        int'(hz.fwd_Rn),        e.fn);
        cmp(e.tag, "fwd_Rd",        int'(hz.fwd_Rd),        e.fd);
        cmp(e.tag, "stall_cnt",     int'(hz.stall_cnt),     e.sc);
        cmp(e.tag, "flush_cnt",     int'(hz.flush_cnt),     e.fc);
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    clr();

    tick(); ex("rst_hold", 0, 0, 15, 0, 0, 0, 0, 0);
    tick(); rst_n = 1'b1; ex("rst_release", 0, 0, 15, 0, 0, 0, 0, 0);
    tick(); ex("run_idle", 1, 1, 0, 0, 0, 0, 0, 0);

    // ALU result in S2 forwarded to Rm
    tick(); si(3'b100, 3'd1, 3'd0, 3'd0, 1, 3'd1, 0, 0, 3'd0, 0, 3'd0, 0, 0);
    ex("fwd_s2_rm", 1, 1, 0, 1, 0, 0, 0, 0);

    // S2 beats S4 for Rd, then S4 alone
    tick(); si(3'b001, 3'd0, 3'd0, 3'd3, 1, 3'd3, 0, 0, 3'd0, 1, 3'd3, 0, 0);
    ex("fwd_rd_s2_wins", 1, 1, 0, 0, 0, 1, 0, 0);
    tick(); si(3'b001, 3'd0, 3'd0, 3'd3, 0, 3'd3, 0, 0, 3'd0, 1, 3'd3, 0, 0);
    ex("fwd_rd_s4", 1, 1, 0, 0, 0, 3, 0, 0);

    // S3 over S4 on Rm/Rn, S4 on Rd
    tick(); si(3'b111, 3'd6, 3'd6, 3'd7, 0, 3'd0, 0, 1, 3'd6, 1, 3'd7, 0, 0);
    ex("fwd_s3_s4", 1, 1, 0, 2, 2, 3, 0, 0);

    // load-use on Rn: two bubbles, then S4 forward
    tick(); si(3'b010, 3'd0, 3'd2, 3'd0, 1, 3'd2, 1, 0, 3'd0, 0, 3'd0, 0, 0);
    ex("ld_detect", 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); si(3'b010, 3'd0, 3'd2, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0, 3'd0, 0, 0);
    ex("ld_bubble1", 0, 0, 2, 0, 0, 0, 0, 0);
    tick(); si(3'b010, 3'd0, 3'd2, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 3'd2, 0, 0);
    ex("ld_bubble2", 0, 0, 2, 0, 3, 0, 1, 0);
    tick(); ex("ld_resume", 1, 1, 0, 0, 3, 0, 2, 0);

    // taken branch during first load bubble
    tick(); si(3'b100, 3'd5, 3'd0, 3'd0, 1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0, 0);
    ex("ld2_detect", 1, 1, 0, 0, 0, 0, 2, 0);
    tick(); si(3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 1, 0);
    ex("br_in_stall", 0, 0, 2, 0, 0, 0, 2, 0);
    tick(); clr(); ex("flush", 1, 1, 7, 0, 0, 0, 3, 1);
    tick(); ex("post_flush", 1, 1, 0, 0, 0, 0, 3, 1);

    // reset in the middle of a load stall
    tick(); si(3'b010, 3'd0, 3'd4, 3'd0, 1, 3'd4, 1, 0, 3'd0, 0, 3'd0, 0, 0);
    ex("ld3_detect", 1, 1, 0, 0, 0, 0, 3, 1);
    tick(); clr(); ex("ld3_bubble1", 0, 0, 2, 0, 0, 0, 3, 1);
    tick(); rst_n = 1'b0; ex("rst_mid_stall", 0, 0, 15, 0, 0, 0, 0, 0);
    tick(); rst_n = 1'b1; ex("rst_release2", 0, 0, 15, 0, 0, 0, 0, 0);
    tick(); ex("run_after_rst", 1, 1, 0, 0, 0, 0, 0, 0);

    // five-cycle halt with a deferred branch
    tick(); si(3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0, 1);
    ex("halt_req", 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); si(3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 1, 1);
    ex("halt1_branch", 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); si(3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0, 1);
    ex("halt2", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); ex("halt3", 0, 0, 0, 0, 0, 0, 2, 0);
    tick(); ex("halt4", 0, 0, 0, 0, 0, 0, 3, 0);
    tick(); clr(); ex("halt5", 0, 0, 0, 0, 0, 0, 4, 0);
    tick(); ex("halt_exit_flush", 1, 1, 7, 0, 0, 0, 5, 1);
    tick(); ex("run_end", 1, 1, 0, 0, 0, 0, 5, 1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
